// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode, ALU and shifter encodings for the datapath controller
//   Provides state_t for the FSM, kind_t for decoded instruction classes,
//   the opcode/op constants and classify() which maps opc/op to a kind.
package ctrl_pkg;
   localparam int IR_W    = 16;
   localparam int RADDR_W = 3;
   typedef enum logic [2:0] {WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM, ERR} state_t;
   typedef enum logic [2:0] {K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN, K_ILL} kind_t;
   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;
   localparam logic [1:0] OP_MOVI = 2'b10;
   localparam logic [1:0] OP_MOVR = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_NOT = 2'b11;
   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;
   function automatic kind_t classify(input logic [2:0] opc, input logic [1:0] op);
      if (opc == OPC_MOV)
         return op == OP_MOVI ? K_MOVI : op == OP_MOVR ? K_MOVR : K_ILL;
      if (opc == OPC_ALU)
         return op == ALU_ADD ? K_ADD : op == ALU_SUB ? K_CMP : op == ALU_AND ? K_AND : K_MVN;
      return K_ILL;
   endfunction
endpackage

// File: rtl/instr_dec.sv
// instr_dec: combinational field extraction and imm8 sign-extension of the latched instruction
//   ir     in  instruction word
//   kind   out decoded instruction class
//   rn/rd/rm out register fields, sh out shift field, op out ALU op field
//   sximm8 out sign-extended ir[7:0]
module instr_dec
   import ctrl_pkg::*;
(
   input  logic [IR_W-1:0]    ir,
   output kind_t              kind,
   output logic [RADDR_W-1:0] rn,
   output logic [RADDR_W-1:0] rd,
   output logic [RADDR_W-1:0] rm,
   output logic [1:0]         sh,
   output logic [1:0]         op,
   output logic [IR_W-1:0]    sximm8
);
   always_comb begin
      kind   = classify(ir[15:13], ir[12:11]);
      op     = ir[12:11];
      rn     = ir[10:8];
      rd     = ir[7:5];
      sh     = ir[4:3];
      rm     = ir[2:0];
      sximm8 = {{8{ir[7]}}, ir[7:0]};
   end
endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle FSM sequencing register-file/ALU/shifter strobes for one instruction
//   clk, reset (async, active-high), s start and instr input accepted in WAIT
//   w ready flag; readnum/writenum/write register-file controls
//   loada/loadb/asel/shift/alu_op/loadc/loads/vsel datapath controls
//   sximm8 sign-extended immediate of the latched instruction; err illegal-instruction pulse
module datapath_ctrl
   import ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               s,
   input  logic [IR_W-1:0]    instr,
   output logic               w,
   output logic [RADDR_W-1:0] readnum,
   output logic [RADDR_W-1:0] writenum,
   output logic               write,
   output logic               loada,
   output logic               loadb,
   output logic               asel,
   output logic [1:0]         shift,
   output logic [1:0]         alu_op,
   output logic               loadc,
   output logic               loads,
   output logic               vsel,
   output logic [IR_W-1:0]    sximm8,
   output logic               err
);
   state_t             state_q, state_d;
   logic [IR_W-1:0]    ir_q, ir_d;
   kind_t              kind;
   logic [RADDR_W-1:0] rn, rd, rm;
   logic [1:0]         sh, op;
   logic               exec;

   instr_dec u_dec (
      .ir     (ir_q),
      .kind   (kind),
      .rn     (rn),
      .rd     (rd),
      .rm     (rm),
      .sh     (sh),
      .op     (op),
      .sximm8 (sximm8)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         WAIT: begin
            state_d = s ? DECODE : WAIT;
            ir_d    = s ? instr : ir_q;
         end
         DECODE: state_d = kind == K_MOVI ? WR_IMM :
                           kind == K_ILL  ? ERR :
                           (kind == K_MOVR || kind == K_MVN) ? GET_B : GET_A;
         GET_A:  state_d = GET_B;
         GET_B:  state_d = EXEC;
         EXEC:   state_d = kind == K_CMP ? WAIT : WR_REG;
         default: state_d = WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= WAIT;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Moore outputs: every strobe depends only on state_q and the latched instruction.
   always_comb begin
      exec     = state_q == EXEC;
      w        = state_q == WAIT;
      readnum  = state_q == GET_A ? rn : state_q == GET_B ? rm : '0;
      loada    = state_q == GET_A;
      loadb    = state_q == GET_B;
      writenum = state_q == WR_REG ? rd : state_q == WR_IMM ? rn : '0;
      write    = state_q == WR_REG || state_q == WR_IMM;
      vsel     = state_q == WR_IMM;
      err      = state_q == ERR;
      shift    = exec ? sh : SH_NONE;
      // MOV reg runs as 0 + shifted Rm, so it needs ADD with Ain forced to zero.
      alu_op   = exec && kind != K_MOVR ? op : ALU_ADD;
      asel     = exec && kind == K_MOVR;
      loadc    = exec && kind != K_CMP;
      loads    = exec && kind != K_MOVR;
   end
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: randomized self-checking bench comparing per-cycle strobes against a trace model
module tb_datapath_ctrl;
   typedef struct packed {
      logic       w;
      logic [2:0] readnum;
      logic [2:0] writenum;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       asel;
      logic [1:0] shift;
      logic [1:0] alu_op;
      logic       loadc;
      logic       loads;
      logic       vsel;
      logic       err;
   } snap_t;

   logic        clk = 0;
   logic        reset;
   logic        s;
   logic [15:0] instr;
   logic        w, write, loada, loadb, asel, loadc, loads, vsel, err;
   logic [2:0]  readnum, writenum;
   logic [1:0]  shift, alu_op;
   logic [15:0] sximm8;
   int          checks = 0;
   int          errors = 0;
   bit          write_seen = 0;
   snap_t       exp_q[$];

   datapath_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .s        (s),
      .instr    (instr),
      .w        (w),
      .readnum  (readnum),
      .writenum (writenum),
      .write    (write),
      .loada    (loada),
      .loadb    (loadb),
      .asel     (asel),
      .shift    (shift),
      .alu_op   (alu_op),
      .loadc    (loadc),
      .loads    (loads),
      .vsel     (vsel),
      .sximm8   (sximm8),
      .err      (err)
   );

   always #5 clk = ~clk;
   always @(posedge write) write_seen = 1;

   function automatic snap_t observe();
      return '{w: w, readnum: readnum, writenum: writenum, write: write, loada: loada,
               loadb: loadb, asel: asel, shift: shift, alu_op: alu_op, loadc: loadc,
               loads: loads, vsel: vsel, err: err};
   endfunction

   function automatic snap_t idle();
      snap_t t = '0;
      t.w = 1;
      return t;
   endfunction

   // Builds the expected strobe snapshot for every cycle after acceptance, ending in WAIT.
   task automatic build_trace(input logic [15:0] ir);
      logic [2:0] opc = ir[15:13];
      logic [1:0] op  = ir[12:11];
      snap_t t;
      bit is_alu = opc == 3'b101;
      bit is_movr = opc == 3'b110 && op == 2'b00;
      bit is_cmp = is_alu && op == 2'b01;
      exp_q = {};
      exp_q.push_back('0);
      if (opc == 3'b110 && op == 2'b10) begin
         t = '0; t.writenum = ir[10:8]; t.write = 1; t.vsel = 1;
         exp_q.push_back(t);
      end else if (is_alu || is_movr) begin
         if (is_alu && op != 2'b11) begin
            t = '0; t.readnum = ir[10:8]; t.loada = 1;
            exp_q.push_back(t);
         end
         t = '0; t.readnum = ir[2:0]; t.loadb = 1;
         exp_q.push_back(t);
         t = '0; t.shift = ir[4:3]; t.alu_op = is_alu ? op : 2'b00; t.asel = is_movr;
         t.loadc = !is_cmp; t.loads = is_alu;
         exp_q.push_back(t);
         if (!is_cmp) begin
            t = '0; t.writenum = ir[7:5]; t.write = 1;
            exp_q.push_back(t);
         end
      end else begin
         t = '0; t.err = 1;
         exp_q.push_back(t);
      end
      exp_q.push_back(idle());
   endtask

   function automatic int spec_latency(input logic [15:0] ir);
      case (ir[15:11])
         5'b11010: return 3;
         5'b11000, 5'b10111: return 5;
         5'b10100, 5'b10110: return 6;
         5'b10101: return 5;
         default: return 3;
      endcase
   endfunction

   task automatic run_instr(input logic [15:0] ir, input bit hold_s, input string name);
      snap_t o;
      int busy = 0;
      logic [15:0] imm = 16'($signed(ir[7:0]));
      build_trace(ir);
      @(negedge clk);
      s = 1;
      instr = ir;
      @(posedge clk);
      #1;
      s = hold_s;
      instr = 16'($urandom);
      for (int i = 0; i < exp_q.size(); i++) begin
         o = observe();
         busy += o.w ? 0 : 1;
         checks++;
         if (o !== exp_q[i]) begin
            errors++;
            $display("FAIL %s ir=%h cycle %0d strobes got=%b want=%b", name, ir, i, o, exp_q[i]);
         end
         checks++;
         if (sximm8 !== imm) begin
            errors++;
            $display("FAIL %s ir=%h cycle %0d sximm8 got=%h want=%h", name, ir, i, sximm8, imm);
         end
         if (i < exp_q.size() - 1) begin
            @(posedge clk);
            #1;
         end
      end
      checks++;
      if (busy + 1 != spec_latency(ir)) begin
         errors++;
         $display("FAIL %s ir=%h latency got=%0d want=%0d", name, ir, busy + 1, spec_latency(ir));
      end
   endtask

   task automatic test_reset();
      reset = 1;
      s = 0;
      instr = 16'hFFFF;
      #12;
      checks++;
      if (observe() !== idle() || sximm8 !== 16'h0000) begin
         errors++;
         $display("FAIL reset_values got=%b sximm8=%h want=%b sximm8=0000", observe(), sximm8, idle());
      end
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_mid_reset();
      snap_t o;
      write_seen = 0;
      @(negedge clk);
      s = 1;
      instr = 16'hA148;
      @(posedge clk);
      #1;
      s = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (loadc !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_exec loadc got=%b want=1", loadc);
      end
      #2;
      reset = 1;
      #1;
      o = observe();
      checks++;
      if (o !== idle() || sximm8 !== 16'h0000) begin
         errors++;
         $display("FAIL mid_reset_async got=%b sximm8=%h want=%b sximm8=0000", o, sximm8, idle());
      end
      @(negedge clk);
      reset = 0;
      @(posedge clk);
      #1;
      checks++;
      if (observe() !== idle() || write_seen) begin
         errors++;
         $display("FAIL mid_reset_after got=%b write_seen=%b want=%b write_seen=0", observe(), write_seen, idle());
      end
   endtask

   task automatic test_directed();
      write_seen = 0;
      run_instr(16'hA900, 0, "cmp");
      checks++;
      if (write_seen) begin
         errors++;
         $display("FAIL cmp_no_write write_seen got=1 want=0");
      end
      run_instr(16'hD007, 0, "mov_imm7");
      run_instr(16'hD5FF, 0, "mov_imm_neg");
      run_instr(16'hA148, 0, "add_lsl");
      run_instr(16'hB861, 0, "mvn");
      run_instr(16'h0000, 0, "illegal");
      run_instr(16'hC018, 0, "mov_reg_asr");
      run_instr(16'hB6DB, 0, "and_same_regs");
   endtask

   task automatic test_held_start();
      int n = 0;
      run_instr(16'hA148, 1, "held_s");
      @(posedge clk);
      #1;
      checks++;
      if (w !== 1'b0) begin
         errors++;
         $display("FAIL held_s_restart w got=%b want=0", w);
      end
      s = 0;
      while (w !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (w !== 1'b1) begin
         errors++;
         $display("FAIL held_s_timeout w got=%b want=1", w);
      end
   endtask

   task automatic test_random();
      logic [15:0] ir;
      for (int k = 0; k < 60; k++) begin
         ir = 16'($urandom);
         case ($urandom_range(0, 3))
            0: ir[15:13] = 3'b110;
            1, 2: ir[15:13] = 3'b101;
            default: ;
         endcase
         run_instr(ir, 0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mid_reset();
      test_held_start();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
